tea_engine: RTL
===============

Name: tea_engine

Overview:
Parametrised iterative TEA block cipher engine and the successor to the fixed-mode `cipher` core. A per-request mode bit selects encrypt or decrypt. Round count and rounds-per-clock (unroll factor) are set by parameters. Start/ready handshake supports back-to-back blocks. Sits between the key/data register file and the stream framing logic.

Parameters:
WORD_SIZE, 32, half-block and key-word width in bits; all arithmetic is modulo 2^WORD_SIZE.
DELTA, 32'h9e3779b9, key-schedule constant, truncated to WORD_SIZE.
ROUND_NUMBER, 32, TEA cycles per block; must be ≥1.
ROUNDS_PER_CYCLE, 1, rounds computed per clock; must divide ROUND_NUMBER (elaboration-time check, $error on violation).

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous active-high reset.
iStart  input  1  request; accepted on a rising edge where iStart=1 and oReady=1.
iDecrypt  input  1  mode, sampled at accept; 0 = encrypt, 1 = decrypt.
iV0  input  WORD_SIZE  block half 0, sampled at accept.
iV1  input  WORD_SIZE  block half 1, sampled at accept.
iK0..iK3  input  WORD_SIZE each  key words, sampled at accept; later changes have no effect on the running block.
oReady  output  1  engine can accept a request.
oC0  output  WORD_SIZE  result half 0.
oC1  output  WORD_SIZE  result half 1.
oDone  output  1  one-cycle pulse; oC0/oC1 are valid.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, oReady=1, oDone=0, oC0=oC1=0, sum=0, round counter=0. Applies from any state; an in-flight block is discarded and oDone does not pulse for it.
- States:
  - IDLE: oReady=1. On accept: latch v0/v1, k0..k3 and mode; go to RUN.
  - RUN: oReady=0. Each edge applies ROUNDS_PER_CYCLE rounds. After N = ROUND_NUMBER/ROUNDS_PER_CYCLE RUN edges, go to DONE.
  - DONE: oDone=1, oReady=1. On accept: latch the new block, go to RUN (back-to-back). Otherwise go to IDLE.
- Latency: oDone is high during the cycle that starts N edges after the accept edge. Throughput is one block per N+1 cycles.
- iStart while oReady=0 is ignored; there is no queueing.
- oC0/oC1 update only on the edge entering DONE and hold until the next DONE or reset. They do not show intermediate rounds.
- Encrypt:
  - Initial sum=0.
  - Per round: sum+=DELTA; v0 += ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1); v1 += ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3), where the v1 update uses the new v0.
- Decrypt:
  - Initial sum = DELTA*ROUND_NUMBER mod 2^WORD_SIZE, computed as a constant.
  - Per round: v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3); v0 -= ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1), using the new v1; then sum-=DELTA.
- Shifts are logical. All adds and subtracts wrap; no carry out.
- Round counter is width clog2(N+1) and counts RUN edges.

Decomposition:
- Shared package tea_pkg: state encoding (IDLE, RUN, DONE), default DELTA, a function computing the decrypt initial sum, and the ROUNDS_PER_CYCLE divisibility-check macro.
- Sub-module tea_round: combinational single round. Inputs: v0, v1, sum, keys, mode. Outputs: next v0, v1, sum.
- tea_engine instantiates ROUNDS_PER_CYCLE copies of tea_round in a generate chain, plus the FSM and registers.

Test Plan:
1. Defaults; key=0, V=0, encrypt → oDone pulse 32 cycles after accept; {oC0,oC1}=41ea3a0a_94baa940. Then decrypt of that result returns 0_0.
2. Key {132acf42,234acb45,3235acbe,4533f235}, V={d5db9e6a,f5509056}: encrypt, then feed the result back with iDecrypt=1 → returns d5db9e6a_f5509056. Both directions match the C golden model.
3. Back-to-back: assert iStart during DONE with a new block → accepted with no IDLE cycle. Two oDone pulses 33 cycles apart. iStart pulses during RUN are ignored (exactly 2 results).
4. rst=1 at RUN cycle 10 → next cycle oReady=1, oDone=0, oC=0. No oDone for the aborted block. A fresh request afterwards gives the correct result.
5. ROUNDS_PER_CYCLE=4, ROUND_NUMBER=32 → latency 8 cycles, results identical to scenario 2. ROUND_NUMBER=16 → result matches the 16-round golden model.
6. Change iK*/iV*/iDecrypt every cycle during RUN → result equals the one for the values latched at accept.

Source files
------------

// File: rtl/tea_pkg.sv
// ---------------------------------------------------------------------------
// tea_pkg
// Shared definitions for the TEA engine: FSM state encoding, the default
// key-schedule constant, the decrypt starting-sum helper and the
// ROUNDS_PER_CYCLE divisibility check used at elaboration.
// ---------------------------------------------------------------------------
package tea_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tea_state_e;

    localparam logic [31:0] DEFAULT_DELTA = 32'h9e3779b9;

    // Decrypt starts from the sum encryption finishes on: DELTA * rounds.
    // Computed at 64 bits; the caller truncates to its word size, which gives
    // the product modulo 2^WORD_SIZE for any WORD_SIZE up to 64.
    function automatic logic [63:0] decrypt_start_sum(input logic [63:0] delta,
                                                      input int unsigned rounds);
        return delta * 64'(rounds);
    endfunction

endpackage

// Elaboration-time guard: the round chain has to tile the round count
// exactly, otherwise the last clock would apply rounds that do not exist.
`define TEA_CHECK_RPC(RN, RPC) \
    if ((RN) < 1 || (RPC) < 1 || ((RN) % (RPC)) != 0) begin : g_rpc_check \
        $error("tea_engine: ROUNDS_PER_CYCLE must divide ROUND_NUMBER (>=1)"); \
    end

// File: rtl/tea_round.sv
// ---------------------------------------------------------------------------
// tea_round
// One combinational TEA cycle in either direction.
//   v0, v1      : block halves entering the round
//   sum         : running key-schedule sum entering the round
//   k0..k3      : key words
//   decrypt     : 0 = encrypt round, 1 = decrypt round
//   v0_next, v1_next, sum_next : values leaving the round
// ---------------------------------------------------------------------------
module tea_round
    import tea_pkg::*;
#(
    parameter int                    WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0]  DELTA     = WORD_SIZE'(DEFAULT_DELTA)
) (
    input  logic [WORD_SIZE-1:0] v0,
    input  logic [WORD_SIZE-1:0] v1,
    input  logic [WORD_SIZE-1:0] sum,
    input  logic [WORD_SIZE-1:0] k0,
    input  logic [WORD_SIZE-1:0] k1,
    input  logic [WORD_SIZE-1:0] k2,
    input  logic [WORD_SIZE-1:0] k3,
    input  logic                 decrypt,
    output logic [WORD_SIZE-1:0] v0_next,
    output logic [WORD_SIZE-1:0] v1_next,
    output logic [WORD_SIZE-1:0] sum_next
);

    // TEA mixing term; shifts are logical and all adds wrap at WORD_SIZE.
    function automatic logic [WORD_SIZE-1:0] mix(input logic [WORD_SIZE-1:0] v,
                                                 input logic [WORD_SIZE-1:0] s,
                                                 input logic [WORD_SIZE-1:0] ka,
                                                 input logic [WORD_SIZE-1:0] kb);
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

    logic [WORD_SIZE-1:0] sum_enc, v0_enc, v1_enc;
    logic [WORD_SIZE-1:0] v0_dec, v1_dec;

    // Encrypt advances the sum first; the v1 update sees the new v0.
    assign sum_enc = sum + DELTA;
    assign v0_enc  = v0 + mix(v1, sum_enc, k0, k1);
    assign v1_enc  = v1 + mix(v0_enc, sum_enc, k2, k3);

    // Decrypt undoes the halves in reverse order, then retreats the sum.
    assign v1_dec  = v1 - mix(v0, sum, k2, k3);
    assign v0_dec  = v0 - mix(v1_dec, sum, k0, k1);

    assign v0_next  = decrypt ? v0_dec : v0_enc;
    assign v1_next  = decrypt ? v1_dec : v1_enc;
    assign sum_next = decrypt ? (sum - DELTA) : sum_enc;

endmodule

// File: rtl/tea_engine.sv
// ---------------------------------------------------------------------------
// tea_engine
// Iterative TEA block cipher, encrypt or decrypt selected per request.
//   clk, rst        : clock, synchronous active-high reset
//   iStart          : request, accepted when oReady is high
//   iDecrypt        : mode latched at accept (1 = decrypt)
//   iV0, iV1        : block halves latched at accept
//   iK0..iK3        : key words latched at accept
//   oReady          : engine can accept a request (IDLE or DONE)
//   oC0, oC1        : result, updated only when a block completes
//   oDone           : one-cycle pulse while the new result is presented
// ---------------------------------------------------------------------------
module tea_engine
    import tea_pkg::*;
#(
    parameter int                    WORD_SIZE        = 32,
    parameter logic [WORD_SIZE-1:0]  DELTA            = WORD_SIZE'(DEFAULT_DELTA),
    parameter int                    ROUND_NUMBER     = 32,
    parameter int                    ROUNDS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iStart,
    input  logic                 iDecrypt,
    input  logic [WORD_SIZE-1:0] iV0,
    input  logic [WORD_SIZE-1:0] iV1,
    input  logic [WORD_SIZE-1:0] iK0,
    input  logic [WORD_SIZE-1:0] iK1,
    input  logic [WORD_SIZE-1:0] iK2,
    input  logic [WORD_SIZE-1:0] iK3,
    output logic                 oReady,
    output logic [WORD_SIZE-1:0] oC0,
    output logic [WORD_SIZE-1:0] oC1,
    output logic                 oDone
);

    `TEA_CHECK_RPC(ROUND_NUMBER, ROUNDS_PER_CYCLE)

    localparam int N     = ROUND_NUMBER / ROUNDS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [WORD_SIZE-1:0] SUM_DEC =
        WORD_SIZE'(decrypt_start_sum(64'(DELTA), ROUND_NUMBER));

    tea_state_e state_q, state_d;

    logic [WORD_SIZE-1:0] v0_q, v1_q, sum_q;
    logic [WORD_SIZE-1:0] k0_q, k1_q, k2_q, k3_q;
    logic                 decrypt_q;
    logic [CNT_W-1:0]     cnt_q;

    logic accept;
    logic last_run;

    assign accept   = iStart && oReady;
    assign last_run = (state_q == RUN) && (cnt_q == CNT_W'(N - 1));

    // ---------------- round chain ----------------
    logic [WORD_SIZE-1:0] v0_ch  [ROUNDS_PER_CYCLE+1];
    logic [WORD_SIZE-1:0] v1_ch  [ROUNDS_PER_CYCLE+1];
    logic [WORD_SIZE-1:0] sum_ch [ROUNDS_PER_CYCLE+1];

    assign v0_ch[0]  = v0_q;
    assign v1_ch[0]  = v1_q;
    assign sum_ch[0] = sum_q;

    for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_round
        tea_round #(
            .WORD_SIZE (WORD_SIZE),
            .DELTA     (DELTA)
        ) u_round (
            .v0       (v0_ch[r]),
            .v1       (v1_ch[r]),
            .sum      (sum_ch[r]),
            .k0       (k0_q),
            .k1       (k1_q),
            .k2       (k2_q),
            .k3       (k3_q),
            .decrypt  (decrypt_q),
            .v0_next  (v0_ch[r+1]),
            .v1_next  (v1_ch[r+1]),
            .sum_next (sum_ch[r+1])
        );
    end

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        oReady  = 1'b1;
        oDone   = 1'b0;
        unique case (state_q)
            IDLE: if (iStart) state_d = RUN;
            RUN: begin
                oReady = 1'b0;
                if (last_run) state_d = DONE;
            end
            DONE: begin
                oDone   = 1'b1;
                state_d = iStart ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- control / result registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            cnt_q <= '0;
            oC0   <= '0;
            oC1   <= '0;
        end else if (accept) begin
            sum_q <= iDecrypt ? SUM_DEC : '0;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            sum_q <= sum_ch[ROUNDS_PER_CYCLE];
            cnt_q <= cnt_q + 1'b1;
            if (last_run) begin
                oC0 <= v0_ch[ROUNDS_PER_CYCLE];
                oC1 <= v1_ch[ROUNDS_PER_CYCLE];
            end
        end
    end

    // ---------------- block / key registers ----------------
    // NOTE: these are always loaded at accept before anything reads them, so
    // they carry no reset and stay plain enabled flops.
    always_ff @(posedge clk) begin
        if (accept) begin
            v0_q      <= iV0;
            v1_q      <= iV1;
            k0_q      <= iK0;
            k1_q      <= iK1;
            k2_q      <= iK2;
            k3_q      <= iK3;
            decrypt_q <= iDecrypt;
        end else if (state_q == RUN) begin
            v0_q <= v0_ch[ROUNDS_PER_CYCLE];
            v1_q <= v1_ch[ROUNDS_PER_CYCLE];
        end
    end

endmodule
